// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: debounced keys, bit-reversed operand capture,
// LSB-first drive of an external full adder and WIDTH+1-bit result assembly.

module key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_PRE = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] cnt;

    // Counter saturates at DEB_MAX, so a held key pulses only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= !key && (cnt == DEB_PRE);
            if (key) begin
                cnt <= '0;
            end else if (cnt != DEB_MAX) begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

module serial_add_ctrl #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key,
    input  logic [WIDTH-1:0] sw,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             busy,
    output logic [1:0]       state_led
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       press;
    logic             do_clr;
    logic             do_start;
    logic             do_ld_a;
    logic             do_ld_b;
    logic             in_add;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:1] sum_sh;
    logic [WIDTH-1:0] sum_ext;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             a_loaded;
    logic             b_loaded;
    logic [WIDTH-1:0] sw_rev;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .key  (key[i]),
            .press(press[i])
        );
    end

    // sw[0] is the operand MSB on the board.
    always_comb begin
        sw_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sw_rev[i] = sw[WIDTH-1-i];
        end
    end

    assign in_add = (state == ADD);

    always_comb begin
        do_clr   = press[3];
        do_start = 1'b0;
        do_ld_a  = 1'b0;
        do_ld_b  = 1'b0;
        if (!in_add && !press[3]) begin
            if (press[2]) begin
                do_start = 1'b1;
            end else if (press[0]) begin
                do_ld_a = 1'b1;
            end else if (press[1]) begin
                do_ld_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (do_start) begin
                    state_next = ADD;
                end else if (do_ld_a || do_ld_b) begin
                    state_next = IDLE;
                end
            end
            ADD: begin
                if (bit_cnt == LAST) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (do_clr) begin
            state_next = IDLE;
        end
    end

    // Sum bits enter from the top; the final one lands directly in result.
    assign sum_ext = {fa_s, sum_sh};

    always_ff @(posedge clk) begin
        if (rst || do_clr) begin
            op_a     <= '0;
            op_b     <= '0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            result   <= '0;
        end else begin
            if (do_ld_a) begin
                op_a     <= sw_rev;
                a_loaded <= 1'b1;
            end
            if (do_ld_b) begin
                op_b     <= sw_rev;
                b_loaded <= 1'b1;
            end
            if (do_start) begin
                a_sh    <= op_a;
                b_sh    <= op_b;
                sum_sh  <= '0;
                carry   <= 1'b0;
                bit_cnt <= '0;
            end
            if (in_add) begin
                a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                sum_sh  <= sum_ext[WIDTH-1:1];
                carry   <= fa_cout;
                bit_cnt <= bit_cnt + CW'(1);
                if (bit_cnt == LAST) begin
                    result <= {fa_cout, sum_ext};
                end
            end
        end
    end

    assign fa_a         = in_add & a_sh[0];
    assign fa_b         = in_add & b_sh[0];
    assign fa_cin       = in_add & carry;
    assign busy         = in_add;
    assign result_valid = (state == DONE);
    assign state_led    = {b_loaded, a_loaded};

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder
// and hand-computed expected values.

module tb_serial_add_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       key;
    logic [WIDTH-1:0] sw;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             busy;
    logic [1:0]       state_led;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(
        .WIDTH(WIDTH),
        .DEB_CYCLES(20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .sw          (sw),
        .fa_a        (fa_a),
        .fa_b        (fa_b),
        .fa_cin      (fa_cin),
        .fa_s        (fa_s),
        .fa_cout     (fa_cout),
        .op_a        (op_a),
        .op_b        (op_b),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .state_led   (state_led)
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Press m1 at cycle 0 and m2 at cycle off, release all at 30,
    // observe 60 cycles counting busy cycles and carry-in per ADD cycle.
    task automatic seq(input logic [3:0] m1, input logic [3:0] m2,
                       input int off, output int nb,
                       output logic [3:0] cin, output logic rv_edge);
        logic pb;
        nb      = 0;
        cin     = '0;
        rv_edge = 1'b0;
        pb      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) key = key & ~m1;
            if (i == off) key = key & ~m2;
            if (i == 30) key = 4'hF;
            if (busy) begin
                if (nb < 4) cin[nb[1:0]] = fa_cin;
                nb++;
            end
            if (pb && !busy) rv_edge = result_valid;
            pb = busy;
        end
    endtask

    task automatic load(input logic [3:0] m, input logic [3:0] s);
        int nb;
        logic [3:0] cin;
        logic rv;
        sw = s;
        seq(m, 4'h0, 1, nb, cin, rv);
    endtask

    int nb;
    logic [3:0] cin;
    logic rv;
    logic hit;

    initial begin
        rst = 1'b1;
        key = 4'hF;
        sw  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_led", state_led, 0);
        check("rst_opa", op_a, 0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 0);

        // 5 + 3
        load(4'b0001, 4'b1010);
        check("ld_a5", op_a, 5);
        check("led_a", state_led, 2'b01);
        load(4'b0010, 4'b1100);
        check("ld_b3", op_b, 3);
        check("led_ab", state_led, 2'b11);
        seq(4'b0100, 4'h0, 1, nb, cin, rv);
        check("busy_5p3", nb, 4);
        check("res_5p3", result, 8);
        check("valid_5p3", result_valid, 1);
        check("vedge_5p3", rv, 1);
        check("led_start", state_led, 2'b11);

        // 15 + 15, load from DONE drops valid
        load(4'b0001, 4'b1111);
        check("valid_drop", result_valid, 0);
        check("ld_a15", op_a, 15);
        load(4'b0010, 4'b1111);
        seq(4'b0100, 4'h0, 1, nb, cin, rv);
        check("busy_15", nb, 4);
        check("res_15p15", result, 30);
        check("carry_seq", cin, 4'b1110);
        check("vedge_15", rv, 1);

        // 0 + 0
        load(4'b0001, 4'b0000);
        load(4'b0010, 4'b0000);
        seq(4'b0100, 4'h0, 1, nb, cin, rv);
        check("res_0p0", result, 0);
        check("valid_0p0", result_valid, 1);

        // clear, then short presses must not load
        load(4'b1000, 4'b0000);
        check("clr_led", state_led, 0);
        sw = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            key[0] = 1'b0;
            repeat (10) @(negedge clk);
            key = 4'hF;
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("short_opa", op_a, 0);
        check("short_led", state_led, 0);

        // long hold with switch change after the pulse: single load only
        sw = 4'b1001;
        key[0] = 1'b0;
        repeat (22) @(negedge clk);
        check("hold_ld9", op_a, 9);
        sw = 4'b0100;
        repeat (30) @(negedge clk);
        key = 4'hF;
        repeat (3) @(negedge clk);
        check("hold_once", op_a, 9);
        check("hold_led", state_led, 2'b01);

        // 9 + 6 with a load A pulse landing in ADD cycle 2
        load(4'b0010, 4'b0110);
        check("ld_b6", op_b, 6);
        sw = 4'b0010;
        seq(4'b0100, 4'b0001, 2, nb, cin, rv);
        check("busy_9p6", nb, 4);
        check("res_9p6", result, 15);
        check("opa_kept", op_a, 9);
        check("valid_9p6", result_valid, 1);

        // rst in ADD cycle 2
        key[2] = 1'b0;
        nb  = 0;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (nb == 2) hit = 1'b1;
        end
        check("rst_hit", hit, 1);
        rst = 1'b1;
        key = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        check("arst_busy", busy, 0);
        check("arst_res", result, 0);
        check("arst_valid", result_valid, 0);
        check("arst_ops", {op_a, op_b}, 0);
        check("arst_led", state_led, 0);
        check("arst_cin", fa_cin, 0);
        repeat (3) @(negedge clk);

        // clear in ADD cycle 2
        load(4'b0001, 4'b1001);
        load(4'b0010, 4'b0110);
        seq(4'b0100, 4'b1000, 2, nb, cin, rv);
        check("clr_busy_n", nb, 2);
        check("clr_busy", busy, 0);
        check("clr_res", result, 0);
        check("clr_ops", {op_a, op_b}, 0);
        check("clr_led2", state_led, 0);

        // clear and start coincide
        load(4'b0001, 4'b1001);
        seq(4'b1100, 4'h0, 1, nb, cin, rv);
        check("cs_busy_n", nb, 0);
        check("cs_led", state_led, 0);
        check("cs_opa", op_a, 0);

        // load A and load B coincide
        sw = 4'b1110;
        seq(4'b0011, 4'h0, 1, nb, cin, rv);
        check("ab_opa", op_a, 7);
        check("ab_opb", op_b, 0);
        check("ab_led", state_led, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for a bit-serial adder on the board.
- Debounces the push keys and captures two WIDTH-bit operands from the switches.
- Drives an external 1-bit full adder LSB-first, one bit per clock, and assembles the WIDTH+1-bit sum.
- Exposes status for the LEDs and the result for the seven-segment display driver.

Parameters:
WIDTH, 4, operand width in bits (number of serial add cycles)
DEB_CYCLES, 20, consecutive stable-low samples required to accept a key press (board value is larger; 20 is for simulation)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key  input  4  push keys, active-low; [0] load A, [1] load B, [2] start, [3] clear
sw  input  WIDTH  operand switches; sw[0] is the operand MSB (bit-reversed capture)
fa_a  output  1  serial operand A bit to full adder
fa_b  output  1  serial operand B bit to full adder
fa_cin  output  1  carry into full adder
fa_s  input  1  full adder sum (combinational from fa_a/fa_b/fa_cin)
fa_cout  output? no: input  1  full adder carry out (combinational)
op_a  output  WIDTH  captured operand A
op_b  output  WIDTH  captured operand B
result  output  WIDTH+1  {carry, sum}, valid when result_valid=1
result_valid  output  1  high in DONE
busy  output  1  high in ADD
state_led  output  2  {b_loaded, a_loaded}

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: every output and internal register is 0; FSM in IDLE; all debounce counters are 0.
- Debounce, per key i:
  - A counter increments while key[i]==0 and clears to 0 when key[i]==1.
  - A press pulse lasts one cycle, on the cycle the counter reaches DEB_CYCLES.
  - The counter saturates there, so holding the key never gives a second pulse.
  - The key must return high for at least 1 cycle before it can pulse again.
  - A low shorter than DEB_CYCLES gives no pulse.
- Priority when pulses coincide: rst > clear > start > load A > load B. Only the highest-priority pulse acts; lower ones in the same cycle are discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE / DONE:
  - Load A pulse: op_a <= bit-reversed sw, a_loaded <= 1, state -> IDLE, result_valid drops.
  - Load B pulse: same, into op_b and b_loaded.
  - Start pulse: always accepted, even if unloaded; operands read as held (0 after reset/clear). It copies op_a and op_b into shift registers, clears the carry flop and bit counter, and enters ADD the next cycle.
- ADD:
  - Combinational outputs: fa_a = a_sh[0], fa_b = b_sh[0], fa_cin = carry flop.
  - Each cycle: sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}; carry <= fa_cout; a_sh and b_sh shift right by 1; counter increments.
  - After exactly WIDTH ADD cycles: result <= {carry_final, sum}, and the state is DONE.
  - Latency: start pulse in cycle t puts ADD in cycles t+1 .. t+WIDTH, with result_valid=1 from cycle t+WIDTH+1.
- fa_a, fa_b and fa_cin are 0 outside ADD.
- Start or load pulses during ADD are ignored: no queuing, no effect on the operands.
- Clear pulse in any state, including mid-ADD: the same effect as rst, except the debounce counters keep running.
- DONE holds result and result_valid until the next accepted load, start or clear. A new start from DONE drops result_valid in the next cycle.
- busy = (state == ADD). state_led follows the loaded flags and is unaffected by start.
- Arithmetic: the result is an unsigned WIDTH+1-bit sum. The carry is only ever the final carry, with no overflow flag.
- rst asserted mid-ADD aborts the addition. result is 0 in the cycle after rst.

Test Plan:
- rst, then hold key[0] low 25 cycles with sw=4'b1010 (reversed gives 5); then key[1] the same way with sw=4'b1100 (gives 3); then key[2] -> op_a=5, op_b=3, state_led=2'b11, busy for exactly 4 cycles, then result=5'd8 and result_valid=1.
- A=15, B=15, start -> result=5'b11110 (30); the carry flop is seen =1 during ADD cycles 2-4; A=0, B=0 -> result=0.
- Key[0] low for 10 cycles then high, repeated 5 times -> no load, op_a unchanged, a_loaded=0. One 25-cycle hold -> exactly one load pulse.
- During ADD of 9+6: pulse key[2] and key[0] with sw changed -> the addition completes with result=5'd15, op_a still 9, no second ADD.
- rst high for 1 cycle in ADD cycle 2 -> next cycle state IDLE, busy=0, result=0, op_a=op_b=0, state_led=0. The same check with a key[3] clear press.
- key[3] and key[2] reach DEB_CYCLES in the same cycle -> clear wins, no ADD entered. Key[0] and key[1] together -> only A is loaded.
